regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the datapath register file: configurable data width, depth and read-port count, optional hardwired zero register, optional write-to-read bypass.
- Storage is cleared by an internal sequencer (one entry per cycle) after reset, so the array can map to RAM-style storage without a parallel reset.
- Sits in the datapath between decode (read addresses) and writeback (write port).
- Busy tells the pipeline controller to stall until the clear has finished.

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of registers (≥2; need not be a power of two).
- AW, 5, address width; must satisfy 2**AW ≥ DEPTH.
- NUM_RD, 2, number of read ports.
- ZERO_REG, 1, if 1 then register 0 always reads 0 and writes to it are dropped.
- BYPASS, 1, if 1 then a same-cycle write to a read address is forwarded to that read port.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- RS  in  NUM_RD*AW  read addresses; port k uses bits [k*AW +: AW].
- RD  in  AW  write address.
- WData  in  DW  write data.
- RegWr  in  1  write enable.
- RData  out  NUM_RD*DW  read data; port k uses bits [k*DW +: DW].
- Busy  out  1  high while reset or clear is in progress.
- WrDrop  out  1  one-cycle pulse, registered, when a write request was discarded.

Behaviour:
- FSM states (from the shared package): CLEAR and READY.
- Reset value: state = CLEAR, ClrIdx = 0, Busy = 1, WrDrop = 0.
- CLEAR state:
  - While Reset is high, ClrIdx is held at 0 and no entry is written.
  - Each cycle with Reset low, mem[ClrIdx] <= 0 and ClrIdx increments.
  - When ClrIdx == DEPTH-1 has been written, the next state is READY.
  - Busy therefore falls exactly DEPTH cycles after the first low-Reset edge.
- Reset asserted in any state, including mid-clear, returns the block to CLEAR with ClrIdx = 0; the clear restarts from entry 0.
- In CLEAR, every RData port reads 0.
- In CLEAR, RegWr=1 is ignored and WrDrop=1 the next cycle. This does not apply in a cycle where Reset is high: there WrDrop=0.
- READY write: if RegWr=1, RD < DEPTH, and not (ZERO_REG && RD == 0), then mem[RD] <= WData on the edge, visible the following cycle.
- READY, RegWr=1 with RD ≥ DEPTH: write dropped, WrDrop=1 next cycle.
- READY, RegWr=1 with RD == 0 and ZERO_REG=1: write dropped silently, WrDrop=0. This is architectural and not an error.
- Reads are combinational, zero latency. For each port k, in priority order:
  1. RS_k ≥ DEPTH → 0.
  2. ZERO_REG && RS_k == 0 → 0.
  3. BYPASS && a valid write this cycle && RD == RS_k → WData.
  4. Otherwise → mem[RS_k].
- Multiple read ports with the same address return identical data.
- A write and a read to the same address in the same cycle with BYPASS=0 returns the old value.
- No width arithmetic other than ClrIdx, which is AW bits wide and never exceeds DEPTH-1.

Decomposition:
- Package regfile_pkg: FSM state enum {CLEAR, READY}, default DW/DEPTH/AW constants, and a helper function for the address-in-range check.
- Sub-module rf_clear_seq: holds the FSM and the ClrIdx counter; outputs clr_we, clr_addr and Busy.
- Top level: storage array, write mux (clear vs. user write), read/bypass logic, WrDrop register.

Test Plan:
- Reset clear, default parameters: assert Reset for 3 cycles, then release → Busy stays 1 for exactly 32 cycles, then 0; every register reads 0.
- Write/read and bypass: after READY, write RD=5, WData=0xDEADBEEF; in the same cycle drive RS port0=5 → with BYPASS=1, port0 = 0xDEADBEEF in that cycle; with BYPASS=0, port0 = 0 that cycle and 0xDEADBEEF the next cycle.
- Zero register: write RD=0, WData=0x1234 → both ports read 0 at RS=0; WrDrop=0.
- Out-of-range address, DEPTH=24, AW=5: write RD=30 → WrDrop pulses for 1 cycle, no register changes, and a read at RS=30 returns 0.
- Reset mid-clear: 10 cycles into CLEAR, pulse Reset for 1 cycle → Busy stays high for 32 cycles after Reset falls; a RegWr during CLEAR gives WrDrop=1 and no write.
- Multi-port, NUM_RD=3: write regs 1, 2, 3 = 0x11, 0x22, 0x33, then set RS={3,1,2} → RData = {0x22, 0x11, 0x33} (ports 2, 1, 0; port 2 occupies the MSB slice).

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// ============================================================================
// regfile_pkg : shared types and helpers for the multi-port register file
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

  localparam int DEF_DW     = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_AW     = 5;
  localparam int DEF_NUM_RD = 2;

  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] depth);
    return (addr < depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_mp_if.sv
// ============================================================================
// regfile_mp_if : decode/writeback bus of the multi-port register file
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int AW     = DEF_AW,
  parameter int NUM_RD = DEF_NUM_RD
);

  logic [NUM_RD*AW-1:0] RS;
  logic [AW-1:0]        RD;
  logic [DW-1:0]        WData;
  logic                 RegWr;
  logic [NUM_RD*DW-1:0] RData;
  logic                 Busy;
  logic                 WrDrop;

  modport master (
    output RS, RD, WData, RegWr,
    input  RData, Busy, WrDrop
  );

  modport slave (
    input  RS, RD, WData, RegWr,
    output RData, Busy, WrDrop
  );

endinterface

`default_nettype wire

// File: rtl/regfile_mp_clear_seq.sv
// ============================================================================
// rf_clear_seq : post-reset sequencer that zeroes one storage entry per cycle
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_clear_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  wire logic          Clk,
  input  wire logic          Reset,
  output logic               clr_we,
  output logic [AW-1:0]      clr_addr,
  output logic               busy
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  rf_state_e       state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_we    = 1'b0;
    case (state_q)
      CLEAR: begin
        // Reset holds the index at zero; nothing is written until it drops.
        if (!Reset) begin
          clr_we = 1'b1;
          if (clr_idx_q == LAST_IDX) begin
            state_d   = READY;
            clr_idx_d = '0;
          end else begin
            clr_idx_d = clr_idx_q + AW'(1);
          end
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  assign clr_addr = clr_idx_q;
  assign busy     = Reset || (state_q == CLEAR);

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// regfile_mp : parametrised multi-read-port register file with sequenced
//              clear, optional zero register and optional write bypass
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = DEF_AW,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  wire logic     Clk,
  input  wire logic     Reset,
  regfile_mp_if.slave   bus
);

  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            busy;

  rf_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .Clk      (Clk),
    .Reset    (Reset),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .busy     (busy)
  );

  // No parallel reset on the array so it can map onto RAM-style storage.
  logic [DW-1:0]   mem_q [DEPTH];

  logic            wr_in_range;
  logic            wr_is_zero;
  logic            user_we;
  logic            wr_drop_d;
  logic            wr_drop_q;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [DW-1:0]   mem_wdata;

  always_comb begin
    wr_in_range = addr_in_range(32'(bus.RD), 32'(DEPTH));
    wr_is_zero  = (ZERO_REG != 0) && (bus.RD == '0);
    user_we     = !busy && bus.RegWr && wr_in_range && !wr_is_zero;
    // Zero-register writes are architectural no-ops, not drops.
    wr_drop_d   = !Reset && bus.RegWr && (busy || !wr_in_range);
    mem_we      = clr_we || user_we;
    mem_waddr   = clr_we ? clr_addr : bus.RD;
    mem_wdata   = clr_we ? '0 : bus.WData;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= wr_drop_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] rs;
    logic          rs_valid;
    logic          rs_hit;

    assign rs       = bus.RS[k*AW +: AW];
    assign rs_valid = !busy
                   && addr_in_range(32'(rs), 32'(DEPTH))
                   && !((ZERO_REG != 0) && (rs == '0));
    assign rs_hit   = (BYPASS != 0) && user_we && (bus.RD == rs);

    assign bus.RData[k*DW +: DW] = !rs_valid ? '0
                                 : rs_hit    ? bus.WData
                                 :             mem_q[rs];
  end

  assign bus.Busy   = busy;
  assign bus.WrDrop = wr_drop_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// tb_regfile_mp : self-checking bench for regfile_mp (two configurations)
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  // dut 0: defaults; dut 1: DEPTH=24, 3 read ports, no zero reg, no bypass
  logic [4:0]  rs_v [2][3];
  logic [4:0]  rd_v [2];
  logic [31:0] wd_v [2];
  logic        we_v [2];

  logic [31:0] m_mem  [2][32];
  int          m_left [2];
  logic        m_drop [2];

  regfile_mp_if #(.DW(32), .AW(5), .NUM_RD(2)) if_a ();
  regfile_mp_if #(.DW(32), .AW(5), .NUM_RD(3)) if_b ();

  assign if_a.RS    = {rs_v[0][1], rs_v[0][0]};
  assign if_a.RD    = rd_v[0];
  assign if_a.WData = wd_v[0];
  assign if_a.RegWr = we_v[0];
  assign if_b.RS    = {rs_v[1][2], rs_v[1][1], rs_v[1][0]};
  assign if_b.RD    = rd_v[1];
  assign if_b.WData = wd_v[1];
  assign if_b.RegWr = we_v[1];

  regfile_mp #(
    .DW(32), .DEPTH(32), .AW(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)
  ) u_dut_a (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (if_a)
  );

  regfile_mp #(
    .DW(32), .DEPTH(24), .AW(5), .NUM_RD(3), .ZERO_REG(0), .BYPASS(0)
  ) u_dut_b (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (if_b)
  );

  function automatic int depth_of(int d);
    return (d == 0) ? 32 : 24;
  endfunction

  function automatic int nrd_of(int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic bit zreg_of(int d);
    return (d == 0);
  endfunction

  function automatic bit byp_of(int d);
    return (d == 0);
  endfunction

  function automatic logic obs_busy(int d);
    return (d == 0) ? if_a.Busy : if_b.Busy;
  endfunction

  function automatic logic obs_drop(int d);
    return (d == 0) ? if_a.WrDrop : if_b.WrDrop;
  endfunction

  function automatic logic [31:0] obs_read(int d, int k);
    return (d == 0) ? if_a.RData[k*32 +: 32] : if_b.RData[k*32 +: 32];
  endfunction

  function automatic logic [31:0] exp_read(int d, int k);
    int a;
    int w;
    bit wr_valid;
    a = int'(rs_v[d][k]);
    w = int'(rd_v[d]);
    if (Reset || m_left[d] > 0) return 32'h0;
    if (a >= depth_of(d)) return 32'h0;
    if (zreg_of(d) && a == 0) return 32'h0;
    wr_valid = we_v[d] && (w < depth_of(d)) && !(zreg_of(d) && w == 0);
    if (byp_of(d) && wr_valid && w == a) return wd_v[d];
    return m_mem[d][a];
  endfunction

  task automatic model_update(int d);
    int w;
    w = int'(rd_v[d]);
    if (Reset) begin
      m_left[d] = depth_of(d);
      m_drop[d] = 1'b0;
      for (int i = 0; i < 32; i++) m_mem[d][i] = 32'h0;
    end else if (m_left[d] > 0) begin
      m_drop[d] = we_v[d];
      m_left[d] = m_left[d] - 1;
    end else begin
      m_drop[d] = 1'b0;
      if (we_v[d]) begin
        if (w >= depth_of(d)) m_drop[d] = 1'b1;
        else if (!(zreg_of(d) && w == 0)) m_mem[d][w] = wd_v[d];
      end
    end
  endtask

  task automatic chk(string tag, int d, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d: observed %h expected %h", tag, d, obs, exp);
    end
  endtask

  // Inputs are applied at the falling edge; outputs checked 1 ns later.
  task automatic check_step(string tag);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk({tag, "/busy"}, d, 32'(obs_busy(d)), 32'(Reset || m_left[d] > 0));
      chk({tag, "/wrdrop"}, d, 32'(obs_drop(d)), 32'(m_drop[d]));
      for (int k = 0; k < nrd_of(d); k++)
        chk($sformatf("%s/rdata%0d", tag, k), d, obs_read(d, k), exp_read(d, k));
    end
    @(posedge Clk);
    for (int d = 0; d < 2; d++) model_update(d);
    @(negedge Clk);
  endtask

  task automatic randomize_inputs(int we_pct);
    for (int d = 0; d < 2; d++) begin
      rd_v[d] = 5'($urandom_range(31, 0));
      wd_v[d] = $urandom;
      we_v[d] = ($urandom_range(99, 0) < we_pct);
      for (int k = 0; k < 3; k++)
        rs_v[d][k] = ($urandom_range(3, 0) == 0) ? rd_v[d] : 5'($urandom_range(31, 0));
    end
  endtask

  task automatic set_both(logic we, logic [4:0] rd, logic [31:0] wd, logic [4:0] rs);
    for (int d = 0; d < 2; d++) begin
      we_v[d] = we;
      rd_v[d] = rd;
      wd_v[d] = wd;
      for (int k = 0; k < 3; k++) rs_v[d][k] = rs;
    end
  endtask

  initial begin
    int first_low [2];
    logic [31:0] val [3];

    for (int d = 0; d < 2; d++) begin
      m_left[d] = depth_of(d);
      m_drop[d] = 1'b0;
      for (int i = 0; i < 32; i++) m_mem[d][i] = 32'h0;
    end
    set_both(1'b0, 5'd0, 32'h0, 5'd0);
    @(negedge Clk);

    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs(50);
      check_step("reset");
    end

    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      randomize_inputs((i == 4) ? 100 : 0);
      check_step("clear_early");
    end

    Reset = 1'b1;
    randomize_inputs(100);
    check_step("reset_mid_clear");
    Reset = 1'b0;

    first_low[0] = -1;
    first_low[1] = -1;
    for (int i = 0; i < 40; i++) begin
      randomize_inputs(30);
      #1;
      for (int d = 0; d < 2; d++)
        if (first_low[d] < 0 && obs_busy(d) === 1'b0) first_low[d] = i;
      check_step("clear_restart");
    end
    chk("busy_len", 0, 32'(first_low[0]), 32'd32);
    chk("busy_len", 1, 32'(first_low[1]), 32'd24);

    set_both(1'b1, 5'd5, 32'hDEADBEEF, 5'd5);
    check_step("bypass_write");
    set_both(1'b0, 5'd5, 32'h0, 5'd5);
    check_step("bypass_after");

    set_both(1'b1, 5'd0, 32'h00001234, 5'd0);
    check_step("zero_write");
    set_both(1'b0, 5'd0, 32'h0, 5'd0);
    check_step("zero_after");

    set_both(1'b1, 5'd30, 32'hCAFEF00D, 5'd30);
    check_step("oor_write");
    set_both(1'b0, 5'd0, 32'h0, 5'd30);
    check_step("oor_after");
    set_both(1'b0, 5'd0, 32'h0, 5'd30);
    check_step("oor_pulse_end");

    val[0] = 32'h11;
    val[1] = 32'h22;
    val[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      set_both(1'b1, 5'(i + 1), val[i], 5'(i + 1));
      check_step("mp_write");
    end
    set_both(1'b0, 5'd0, 32'h0, 5'd0);
    rs_v[1][0] = 5'd3;
    rs_v[1][1] = 5'd1;
    rs_v[1][2] = 5'd2;
    rs_v[0][0] = 5'd3;
    rs_v[0][1] = 5'd3;
    #1;
    chk("mp_concat", 1, if_b.RData[95:64], 32'h22);
    chk("mp_concat", 1, if_b.RData[63:32], 32'h11);
    chk("mp_concat", 1, if_b.RData[31:0],  32'h33);
    chk("mp_same_addr", 0, if_a.RData[63:32], if_a.RData[31:0]);
    check_step("mp_read");

    for (int i = 0; i < 300; i++) begin
      Reset = ($urandom_range(149, 0) == 0);
      randomize_inputs(50);
      check_step("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
